alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands. Single-cycle ops are add, sub, and, or, sll, slr, rol and ror. mul and div are iterative multi-cycle ops. A start/busy/done handshake lets the pipeline stall on long ops. It also produces the Z/N/V flags consumed by the blt/bgt/beq branch logic.

Parameters:
WIDTH, 16, operand/result width in bits (must be a power of 2, >=8)
SHAMT_W, $clog2(WIDTH), localparam; shift-amount bits taken from op_b

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
alu_ctrl  input  4  operation code from ALU control decoder
op_a  input  WIDTH  operand A (rs)
op_b  input  WIDTH  operand B (rt/imm); op_b[SHAMT_W-1:0] is the shift amount
start  input  1  request; sampled only when busy=0
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse: result/flags valid
result  output  WIDTH  primary result (mul low half, div quotient)
result_hi  output  WIDTH  mul high half, div remainder, else 0
flag_z  output  1  result==0
flag_n  output  1  result[WIDTH-1]
flag_v  output  1  signed overflow (add/sub only, else 0)
div_by_zero  output  1  set with done when div and op_b==0

Behaviour:
- Op codes: add 1111, sub 1110, and 1101, or 1100, mul 0001, div 0010, sll 1010, slr 1011, rol 1000, ror 1001. Any other code is illegal.
- Reset (rst=1 at edge): state IDLE; busy, done, result, result_hi, flags and div_by_zero all 0. Reset mid-operation aborts the op; no done is issued.
- Outputs are registered and hold their value until the next done or reset.
- FSM states:
  - IDLE: start with a single-cycle op -> compute and register outputs, done=1 next cycle, stay in IDLE. start with mul -> MUL. start with div -> DIV (busy=1 from the next cycle).
  - MUL / DIV: one bit per cycle for WIDTH cycles (counter WIDTH-1 down to 0), then -> FIN.
  - FIN: apply sign correction, register outputs, done=1, busy=0, -> IDLE.
- Latency from the accepting edge: single-cycle ops 1 clock; mul/div WIDTH+2 clocks (18 at WIDTH=16).
- start while busy=1 is ignored, not queued. done and start may coincide in IDLE; back-to-back single-cycle ops give done every cycle.
- add/sub: wrap modulo 2^WIDTH. V = signed overflow; blt uses N^V.
- and/or: bitwise; V=0.
- Shifts: sll/slr are logical shifts; rol/ror rotate. Shift amount 0 passes op_a through unchanged.
- mul: signed two's-complement, 2*WIDTH-bit product. Magnitudes feed a shift-add datapath; sign is fixed in FIN. result = low half, result_hi = high half; Z/N from the low half; V=0.
- div: signed, truncates toward zero. Remainder takes the dividend's sign. Magnitudes feed a restoring divider. Z/N from the quotient; V=0.
- Divide by zero: quotient all-ones, remainder = op_a, div_by_zero=1, same latency. div_by_zero is cleared on the next done.
- Illegal code: single-cycle; result=0, result_hi=0, Z=1, done=1.

Optional Feature:
ALU_DIV_EN
- Defined: iterative divider present, div behaves as above.
- Undefined: divider logic removed. div completes single-cycle as an illegal code (result 0, result_hi 0, div_by_zero 0); the DIV state is not built.

Decomposition:
- Package alu_pkg: op code localparams (OP_ADD..OP_ROR), FSM state enum (IDLE, MUL, DIV, FIN), WIDTH default.
- One sub-module, alu_iter_muldiv: magnitude shift-add/restoring datapath with bit counter, start/last strobes. The top module keeps the FSM, single-cycle ops, sign handling and flags.

Test Plan:
- add 0x7FFF+0x0001 -> done 1 cycle later; result 0x8000, N=1, V=1, Z=0. Then sub 0x0005-0x0005 -> result 0, Z=1, V=0.
- mul 0xFFFD x 0x0007 -> busy for cycles 1..17, done at cycle 18; result 0xFFEB, result_hi 0xFFFF. A second start at cycle 5 is ignored.
- div 0xFFF9 / 0x0002 -> quotient 0xFFFD, remainder 0xFFFF at cycle 18. Then div 0x1234 / 0 -> result 0xFFFF, result_hi 0x1234, div_by_zero=1.
- Shifts: rol 0x8001 by 1 -> 0x0003; ror 0x0001 by 4 -> 0x1000; sll 0x00F0 by 4 -> 0x0F00; slr 0x8000 by 15 -> 0x0001; sll by 0 -> op_a.
- rst at cycle 8 of a mul -> next edge busy=0, done=0, result=0, no later done; an add then issued completes normally.
- Illegal code 0101 -> done 1 cycle, result 0, Z=1. Rebuild without ALU_DIV_EN: div 0x0010/0x0002 -> done 1 cycle, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execution-stage ALU: operation codes issued by
// the ALU control decoder, the sequencing FSM states and the default width.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] OP_ADD = 4'b1111;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_AND = 4'b1101;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b1010;
    localparam logic [3:0] OP_SLR = 4'b1011;
    localparam logic [3:0] OP_ROL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative magnitude datapath shared by mul and div. One bit is retired per
// clock for WIDTH clocks after i_start. Multiply is shift-add with the
// multiplier in the low register; divide is restoring with the dividend
// shifting out of the low register into the partial remainder.
// On completion: mul -> {o_hi, o_lo} is the 2*WIDTH product magnitude,
//                div -> o_lo is the quotient, o_hi the remainder magnitude.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_mag_a,
    input  logic [WIDTH-1:0] i_mag_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic             r_is_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // One multiply or divide step computed from the current registers.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves a latch.
        w_sum       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift_rem = {r_hi, r_lo[WIDTH-1]};
        w_diff      = w_shift_rem - {1'b0, r_b};
        w_hi_nxt    = w_sum[WIDTH:1];
        w_lo_nxt    = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            // No borrow out of the trial subtraction means the divisor fits.
            if (!w_diff[WIDTH]) begin
                w_hi_nxt = w_diff[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift_rem[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Bit counter: WIDTH-1 down to 0, aborted by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH - 1);
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Datapath registers: load magnitudes on start, step while active.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; they are always loaded on i_start before being read.
        if (i_start) begin
            r_hi     <= '0;
            r_lo     <= i_mag_a;
            r_b      <= i_mag_b;
            r_is_div <= i_is_div;
        end else if (r_active) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign o_last = r_active && (r_cnt == '0);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU. Single-cycle ops (add/sub/and/or/shifts/rotates)
// complete on the accepting edge; mul and div run through the iterative
// magnitude datapath and finish WIDTH+2 clocks after acceptance, with sign
// correction applied in FIN. All outputs are registered and hold until the
// next done or reset.
// Build option: define ALU_DIV_EN to include the iterative divider; without
// it the div code completes single-cycle as an illegal code.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             div_by_zero
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int MSB     = WIDTH - 1;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_flag_z;
    logic             r_flag_n;
    logic             r_flag_v;
    logic             r_div_by_zero;

    // Operation context captured when a mul/div is accepted.
    logic             r_neg_res;
`ifdef ALU_DIV_EN
    logic             r_is_div;
    logic             r_neg_rem;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_op_a;
`endif

    logic               w_op_mul;
    logic               w_op_div;
    logic               w_accept;
    logic               w_iter_start;
    logic               w_single;
    logic [SHAMT_W-1:0] w_shamt;
    logic [2*WIDTH-1:0] w_rot_l;
    logic [2*WIDTH-1:0] w_rot_r;
    logic [WIDTH-1:0]   w_res;
    logic               w_v;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_it_last;
    logic [WIDTH-1:0]   w_it_hi;
    logic [WIDTH-1:0]   w_it_lo;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fin_res;
    logic [WIDTH-1:0]   w_fin_hi;
    logic               w_fin_dbz;

    assign w_op_mul = (alu_ctrl == OP_MUL);
`ifdef ALU_DIV_EN
    assign w_op_div = (alu_ctrl == OP_DIV);
`else
    assign w_op_div = 1'b0;
`endif

    // Requests are only sampled in IDLE; anything arriving while busy is dropped.
    assign w_accept     = (r_state == IDLE) && start;
    assign w_iter_start = w_accept && (w_op_mul || w_op_div);
    assign w_single     = w_accept && !(w_op_mul || w_op_div);

    assign w_shamt = op_b[SHAMT_W-1:0];
    assign w_rot_l = {op_a, op_a} << w_shamt;
    assign w_rot_r = {op_a, op_a} >> w_shamt;

    // Single-cycle result and overflow; illegal codes fall through to zero.
    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                w_res = op_a + op_b;
                w_v   = (op_a[MSB] == op_b[MSB]) && (w_res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                w_res = op_a - op_b;
                w_v   = (op_a[MSB] != op_b[MSB]) && (w_res[MSB] != op_a[MSB]);
            end
            OP_AND:  w_res = op_a & op_b;
            OP_OR:   w_res = op_a | op_b;
            OP_SLL:  w_res = op_a << w_shamt;
            OP_SLR:  w_res = op_a >> w_shamt;
            OP_ROL:  w_res = w_rot_l[2*WIDTH-1:WIDTH];
            OP_ROR:  w_res = w_rot_r[WIDTH-1:0];
            default: w_res = '0;
        endcase
    end

    // Magnitudes fed to the iterative datapath.
    assign w_a_neg = op_a[MSB];
    assign w_b_neg = op_b[MSB];
    assign w_mag_a = w_a_neg ? -op_a : op_a;
    assign w_mag_b = w_b_neg ? -op_b : op_b;

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_iter_start),
        .i_is_div (w_op_div),
        .i_mag_a  (w_mag_a),
        .i_mag_b  (w_mag_b),
        .o_last   (w_it_last),
        .o_hi     (w_it_hi),
        .o_lo     (w_it_lo)
    );

    assign w_prod_mag = {w_it_hi, w_it_lo};
    assign w_prod     = r_neg_res ? -w_prod_mag : w_prod_mag;

    // Sign correction of the iterative result, used in FIN.
    always_comb begin
        w_fin_res = w_prod[WIDTH-1:0];
        w_fin_hi  = w_prod[2*WIDTH-1:WIDTH];
        w_fin_dbz = 1'b0;
`ifdef ALU_DIV_EN
        if (r_is_div) begin
            if (r_b_zero) begin
                w_fin_res = '1;
                w_fin_hi  = r_op_a;
                w_fin_dbz = 1'b1;
            end else begin
                // Quotient truncates toward zero; remainder follows the dividend.
                w_fin_res = r_neg_res ? -w_it_lo : w_it_lo;
                w_fin_hi  = r_neg_rem ? -w_it_hi : w_it_hi;
            end
        end
`endif
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_iter_start) begin
`ifdef ALU_DIV_EN
                    w_state_nxt = w_op_div ? DIV : MUL;
`else
                    w_state_nxt = MUL;
`endif
                end
            end
            MUL: begin
                if (w_it_last) w_state_nxt = FIN;
            end
`ifdef ALU_DIV_EN
            DIV: begin
                if (w_it_last) w_state_nxt = FIN;
            end
`endif
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture sign/context of an accepted mul or div.
    always_ff @(posedge clk) begin
        if (w_iter_start) begin
            r_neg_res <= w_a_neg ^ w_b_neg;
`ifdef ALU_DIV_EN
            r_is_div  <= w_op_div;
            r_neg_rem <= w_a_neg;
            r_b_zero  <= (op_b == '0);
            r_op_a    <= op_a;
`endif
        end
    end

    // Registered outputs: updated only on completion, done pulses one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_result_hi   <= '0;
            r_flag_z      <= 1'b0;
            r_flag_n      <= 1'b0;
            r_flag_v      <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= 1'b0;
            if (w_single) begin
                r_done        <= 1'b1;
                r_result      <= w_res;
                r_result_hi   <= '0;
                r_flag_z      <= (w_res == '0);
                r_flag_n      <= w_res[MSB];
                r_flag_v      <= w_v;
                r_div_by_zero <= 1'b0;
            end else if (r_state == FIN) begin
                r_done        <= 1'b1;
                r_result      <= w_fin_res;
                r_result_hi   <= w_fin_hi;
                r_flag_z      <= (w_fin_res == '0);
                r_flag_n      <= w_fin_res[MSB];
                r_flag_v      <= 1'b0;
                r_div_by_zero <= w_fin_dbz;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign flag_z      = r_flag_z;
    assign flag_n      = r_flag_n;
    assign flag_v      = r_flag_v;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=16). Divider expectations
// follow the ALU_DIV_EN build option.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_z;
    logic         flag_n;
    logic         flag_v;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         n;
        logic         v;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_ctrl    (alu_ctrl),
        .op_a        (op_a),
        .op_b        (op_b),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_hi   (result_hi),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_v      (flag_v),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r, input logic [W-1:0] h,
                           input logic z, input logic n, input logic v, input logic d,
                           input int l);
        vec_t t;
        t.ctrl = c; t.a = a; t.b = b; t.res = r; t.hi = h;
        t.z = z; t.n = n; t.v = v; t.dbz = d; t.lat = l;
        vecs.push_back(t);
    endtask

    // Issue one op from IDLE; lat counts edges from acceptance until done is seen.
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        int cyc;

        // ctrl, a, b, result, result_hi, z, n, v, dbz, latency
        add_vec(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, 1, 1, 0, 1);
        add_vec(OP_SUB, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1, 0, 0, 0, 1);
        add_vec(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 0, 0, 0, 1);
        add_vec(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 0, 0, 1, 0, 1);
        add_vec(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 0, 0, 0, 0, 1);
        add_vec(OP_OR,  16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 0, 1, 0, 0, 1);
        add_vec(OP_ROL, 16'h8001, 16'h0001, 16'h0003, 16'h0000, 0, 0, 0, 0, 1);
        add_vec(OP_ROR, 16'h0001, 16'h0004, 16'h1000, 16'h0000, 0, 0, 0, 0, 1);
        add_vec(OP_SLL, 16'h00F0, 16'h0004, 16'h0F00, 16'h0000, 0, 0, 0, 0, 1);
        add_vec(OP_SLR, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 0, 0, 0, 0, 1);
        add_vec(OP_SLL, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 0, 0, 0, 0, 1);
        add_vec(OP_SLL, 16'hA5A5, 16'h0010, 16'hA5A5, 16'h0000, 0, 1, 0, 0, 1);
        add_vec(4'b0101, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1, 0, 0, 0, 1);
        add_vec(OP_MUL, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 0, 1, 0, 0, 18);
        add_vec(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 1, 0, 0, 0, 18);
        add_vec(OP_MUL, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1, 0, 0, 0, 18);
        add_vec(OP_MUL, 16'h0003, 16'hFFFE, 16'hFFFA, 16'hFFFF, 0, 1, 0, 0, 18);
`ifdef ALU_DIV_EN
        add_vec(OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 0, 1, 0, 0, 18);
        add_vec(OP_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 0, 1, 0, 1, 18);
        add_vec(OP_DIV, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 0, 1, 0, 0, 18);
        add_vec(OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1, 0, 0, 18);
`else
        add_vec(OP_DIV, 16'h0010, 16'h0002, 16'h0000, 16'h0000, 1, 0, 0, 0, 1);
`endif
        add_vec(OP_AND, 16'h00FF, 16'h0F0F, 16'h000F, 16'h0000, 0, 0, 0, 0, 1);

        // Reset state
        rst      = 1'b1;
        start    = 1'b0;
        alu_ctrl = OP_ADD;
        op_a     = '0;
        op_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy",   busy, 0);
        check("reset.done",   done, 0);
        check("reset.result", result, 0);
        check("reset.hi",     result_hi, 0);
        check("reset.flags",  {flag_z, flag_n, flag_v, div_by_zero}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d.latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d.result", i), result, vecs[i].res);
            check($sformatf("v%0d.result_hi", i), result_hi, vecs[i].hi);
            check($sformatf("v%0d.z", i), flag_z, vecs[i].z);
            check($sformatf("v%0d.n", i), flag_n, vecs[i].n);
            check($sformatf("v%0d.v", i), flag_v, vecs[i].v);
            check($sformatf("v%0d.dbz", i), div_by_zero, vecs[i].dbz);
            check($sformatf("v%0d.busy", i), busy, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d.done_pulse", i), done, 0);
        end

        // mul busy profile, ignored start at cycle 5, start coinciding with done
        alu_ctrl = OP_MUL;
        op_a     = 16'hFFFD;
        op_b     = 16'h0007;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        check("mulseq.busy_c1", busy, 1);
        check("mulseq.done_c1", done, 0);
        bad = 0;
        while (cyc < 17) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (cyc == 4) begin
                start    = 1'b1;
                alu_ctrl = OP_ADD;
                op_a     = 16'h0001;
                op_b     = 16'h0001;
            end
        end
        check("mulseq.busy_profile", bad, 0);
        @(posedge clk); #1;
        check("mulseq.done_c18", done, 1);
        check("mulseq.busy_c18", busy, 0);
        check("mulseq.result", result, 16'hFFEB);
        check("mulseq.result_hi", result_hi, 16'hFFFF);
        alu_ctrl = OP_ADD;
        op_a     = 16'h0002;
        op_b     = 16'h0003;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("coincide.done", done, 1);
        check("coincide.result", result, 16'h0005);
        check("coincide.result_hi", result_hi, 16'h0000);
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done !== 1'b0) bad++;
        end
        check("coincide.no_queued_done", bad, 0);
        check("coincide.hold", result, 16'h0005);

        // Back-to-back single-cycle ops
        alu_ctrl = OP_SUB;
        op_a     = 16'h0005;
        op_b     = 16'h0003;
        start    = 1'b1;
        @(posedge clk); #1;
        check("b2b.done0", done, 1);
        check("b2b.res0", result, 16'h0002);
        alu_ctrl = OP_OR;
        op_a     = 16'h1200;
        op_b     = 16'h0034;
        @(posedge clk); #1;
        check("b2b.done1", done, 1);
        check("b2b.res1", result, 16'h1234);
        alu_ctrl = OP_ROR;
        op_a     = 16'h0003;
        op_b     = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b.done2", done, 1);
        check("b2b.res2", result, 16'h8001);
        check("b2b.n2", flag_n, 1);
        @(posedge clk); #1;
        check("b2b.done_drop", done, 0);
        check("b2b.hold", result, 16'h8001);

        // Reset in cycle 8 of a mul aborts it
        alu_ctrl = OP_MUL;
        op_a     = 16'h0100;
        op_b     = 16'h0100;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rstmul.busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmul.busy", busy, 0);
        check("rstmul.done", done, 0);
        check("rstmul.result", result, 0);
        check("rstmul.result_hi", result_hi, 0);
        bad = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rstmul.no_late_done", bad, 0);
        run_op(OP_ADD, 16'h0003, 16'h0004, lat);
        check("rstmul.add_latency", lat, 1);
        check("rstmul.add_result", result, 16'h0007);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
